// File: rtl/fp_expand_pipe_if.sv
// Valid/ready stream bundle for fp_expand_pipe: 8-bit float samples in, 12-bit linear samples out.
// The DUT uses the slave modport; whoever drives samples and consumes results uses master.
interface fp_expand_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_fp;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_lin;

    modport master (
        output in_valid,
        output in_fp,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_lin
    );

    modport slave (
        input  in_valid,
        input  in_fp,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_lin
    );
endinterface

// File: rtl/fp_expand_pipe.sv
// Expands 8-bit floats {sign, exp[2:0], sig[3:0]} back to 12-bit two's-complement samples
// through a 2-stage elastic pipeline, with a peak-magnitude hold and a saturating sample counter.
module fp_expand_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_expand_pipe_if.slave  bus,
    input  logic             peak_clr,
    output logic [10:0]      peak_mag,
    output logic [CNT_W-1:0] sample_cnt
);

    logic        s1_valid;
    logic        s1_sign;
    logic [10:0] s1_mag;
    logic        s2_valid;
    logic [11:0] out_lin_q;

    logic        s1_load;
    logic        s2_load;
    logic        out_hs;
    logic [11:0] s2_lin;
    logic [10:0] out_abs;

    // Stage 2 frees up whenever its current sample leaves, so both stages can move together.
    always_comb begin
        s2_load = s1_valid & (~s2_valid | bus.out_ready);
        s1_load = bus.in_valid & (~s1_valid | s2_load);
        out_hs  = s2_valid & bus.out_ready;
    end

    assign bus.in_ready  = ~s1_valid | ~s2_valid | bus.out_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_lin   = out_lin_q;

    // Negating a zero magnitude wraps to zero, so negative zero needs no special case.
    always_comb begin
        s2_lin  = s1_sign ? (~{1'b0, s1_mag} + 12'd1) : {1'b0, s1_mag};
        out_abs = out_lin_q[11] ? 11'(~out_lin_q + 12'd1) : out_lin_q[10:0];
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_sign <= bus.in_fp[7];
            s1_mag  <= 11'({7'b0, bus.in_fp[3:0]} << bus.in_fp[6:4]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_lin_q <= '0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            s2_valid <= s2_load | (s2_valid & ~out_hs);
            if (s2_load) begin
                out_lin_q <= s2_lin;
            end
        end
    end

    // A clear coinciding with a handshake restarts the peak from that sample rather than zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_mag   <= '0;
            sample_cnt <= '0;
        end else begin
            if (out_hs) begin
                if (peak_clr || (out_abs > peak_mag)) begin
                    peak_mag <= out_abs;
                end
                if (sample_cnt != {CNT_W{1'b1}}) begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end else if (peak_clr) begin
                peak_mag <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_expand_pipe.sv
// Scoreboard bench for fp_expand_pipe: directed samples push hand-computed results into a queue
// that a negedge monitor drains on every output handshake.
module tb_fp_expand_pipe;

    logic        clk;
    logic        rst_n;
    logic        peak_clr;
    logic [10:0] peak_mag;
    logic [15:0] sample_cnt;
    logic [10:0] peak_mag4;
    logic [3:0]  sample_cnt4;

    fp_expand_pipe_if bus ();
    fp_expand_pipe_if bus4 ();

    fp_expand_pipe #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .peak_clr   (peak_clr),
        .peak_mag   (peak_mag),
        .sample_cnt (sample_cnt)
    );

    fp_expand_pipe #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus4),
        .peak_clr   (1'b0),
        .peak_mag   (peak_mag4),
        .sample_cnt (sample_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          accept_waits = 0;
    logic        held = 1'b0;
    logic [11:0] held_val = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offers one sample until accepted (bounded); returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [7:0] fp, input logic [11:0] exp_lin);
        bit accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_fp    = fp;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(exp_lin);
            end else begin
                accept_waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL accept_timeout: got no handshake, expected acceptance of 0x%0h", fp);
        end
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus4.in_valid  = 1'b0;
        peak_clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on handshakes and checks out_lin holds while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", bus.out_lin);
                end else begin
                    checkOutput("out_lin", 32'(bus.out_lin), 32'(exp_q.pop_front()));
                end
                held = 1'b0;
            end else if (bus.out_valid) begin
                if (held) begin
                    checkOutput("hold_stable", 32'(bus.out_lin), 32'(held_val));
                end
                held     = 1'b1;
                held_val = bus.out_lin;
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0]  single_fp  [4] = '{8'h00, 8'h7F, 8'hFF, 8'h80};
    logic [11:0] single_lin [4] = '{12'h000, 12'h780, 12'h880, 12'h000};

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_fp      = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_fp     = '0;
        bus4.out_ready = 1'b1;
        peak_clr       = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_lin", 32'(bus.out_lin), 32'd0);
        checkOutput("rst_peak_mag", 32'(peak_mag), 32'd0);
        checkOutput("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Single samples: invisible after the accept edge, valid after the next one.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(single_fp[i], single_lin[i]);
            @(negedge clk);
            checkOutput("latency_early", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            checkOutput("latency_due", 32'(bus.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        checkOutput("single_cnt", 32'(sample_cnt), 32'd4);
        checkOutput("single_peak", 32'(peak_mag), 32'd1920);

        // Back-to-back at full rate.
        doReset();
        accept_waits = 0;
        applyStimulus(8'h35, 12'h028);
        applyStimulus(8'hB5, 12'hFD8);
        applyStimulus(8'h11, 12'h002);
        cycles(4);
        checkOutput("b2b_no_stall", 32'(accept_waits), 32'd0);
        checkOutput("b2b_cnt", 32'(sample_cnt), 32'd3);
        checkOutput("b2b_peak", 32'(peak_mag), 32'd40);

        // Backpressure: two fill the pipe, the rest wait until out_ready returns.
        doReset();
        bus.out_ready = 1'b0;
        applyStimulus(8'h7F, 12'h780);
        applyStimulus(8'hFF, 12'h880);
        bus.in_valid = 1'b1;
        bus.in_fp    = 8'h35;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_out_lin", 32'(bus.out_lin), 32'h780);
        end
        @(posedge clk);
        #1;
        fork
            begin
                applyStimulus(8'h35, 12'h028);
                applyStimulus(8'h11, 12'h002);
            end
            begin
                cycles(3);
                bus.out_ready = 1'b1;
            end
        join
        cycles(5);
        checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_cnt", 32'(sample_cnt), 32'd4);

        // Peak hold and clear.
        doReset();
        applyStimulus(8'h35, 12'h028);
        applyStimulus(8'hFF, 12'h880);
        applyStimulus(8'h11, 12'h002);
        cycles(4);
        checkOutput("peak_max", 32'(peak_mag), 32'd1920);
        peak_clr = 1'b1;
        cycles(1);
        peak_clr = 1'b0;
        checkOutput("peak_clr_alone", 32'(peak_mag), 32'd0);
        applyStimulus(8'h7F, 12'h780);
        cycles(3);
        checkOutput("peak_regrow", 32'(peak_mag), 32'd1920);
        applyStimulus(8'hB5, 12'hFD8);
        cycles(1);
        peak_clr = 1'b1;
        cycles(1);
        peak_clr = 1'b0;
        checkOutput("peak_clr_hs", 32'(peak_mag), 32'd40);
        checkOutput("peak_cnt", 32'(sample_cnt), 32'd5);

        // Reset with two samples in flight discards them.
        bus.out_ready = 1'b0;
        applyStimulus(8'h7F, 12'h780);
        applyStimulus(8'h35, 12'h028);
        rst_n = 1'b0;
        exp_q.delete();
        cycles(1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_peak", 32'(peak_mag), 32'd0);
        checkOutput("midrst_cnt", 32'(sample_cnt), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cycles(5);
        checkOutput("midrst_no_stale", 32'(sample_cnt), 32'd0);

        // Narrow counter saturates.
        doReset();
        bus4.in_fp    = 8'h11;
        bus4.in_valid = 1'b1;
        cycles(20);
        bus4.in_valid = 1'b0;
        cycles(4);
        checkOutput("cnt4_saturate", 32'(sample_cnt4), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
